sigma_delta_decimator: RTL and testbench

Multi-channel, parametrised first-order sigma-delta modulator with a built-in boxcar (sinc1) decimator. It is the successor of the single-channel fixed-OSR oversampling block. It adds:
- a run-time oversampling ratio,
- per-channel 1-bit bitstream outputs,
- a decimated sample frame delivered over a valid/ready handshake,
- sticky overrun reporting.

It sits between the digitised front-end samples and the downstream filter/DSP chain.

---
 rtl/sigma_delta_pkg.sv | 23 ++
 rtl/sd_mod_ch.sv | 66 ++++++
 rtl/sigma_delta_decimator.sv | 83 ++++++++
 tb/tb_sigma_delta_decimator.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sigma_delta_pkg.sv
// rtl/sigma_delta_pkg.sv - shared helpers for the sigma-delta decimator
package sigma_delta_pkg;

   // Integrator guard bits above the input width, and the smallest usable OSR
   localparam int INTEG_GUARD = 2;
   localparam int OSR_MIN     = 2;

   // Integrator width for a given input width
   function automatic int integ_width(input int data_w);
      return data_w + INTEG_GUARD;
   endfunction

   // Bit position of the feedback magnitude, i.e. |fb| = 2^fb_bit
   function automatic int fb_bit(input int data_w);
      return data_w - 1;
   endfunction

   // Ratios below 2 cannot form a frame, so they are raised to 2
   function automatic int unsigned clamp_osr(input int unsigned osr);
      return (osr < OSR_MIN) ? OSR_MIN : osr;
   endfunction

endpackage

// File: rtl/sd_mod_ch.sv
// rtl/sd_mod_ch.sv - one first-order modulator channel with sinc1 ones counter
module sd_mod_ch
   import sigma_delta_pkg::*;
#(
   parameter int DATA_W = 24,
   parameter int OSR_W  = 8
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              frame_start,
   input  logic              frame_end,
   input  logic [DATA_W-1:0] analog_in,
   output logic              bitstream,
   output logic [OSR_W-1:0]  sample_out
);

   localparam int INTEG_W = integ_width(DATA_W);
   localparam int SUM_W   = INTEG_W + 1;

   localparam logic [SUM_W-1:0]   FB_POS    = SUM_W'(1) << fb_bit(DATA_W);
   localparam logic [SUM_W-1:0]   FB_NEG    = ~FB_POS + SUM_W'(1);
   localparam logic [INTEG_W-1:0] INTEG_MAX = {1'b0, {(INTEG_W-1){1'b1}}};
   localparam logic [INTEG_W-1:0] INTEG_MIN = {1'b1, {(INTEG_W-1){1'b0}}};

   logic [INTEG_W-1:0] integ;
   logic [INTEG_W-1:0] integ_next;
   logic [SUM_W-1:0]   sum;
   logic [SUM_W-1:0]   fb;
   logic [OSR_W-1:0]   ones;
   logic [OSR_W-1:0]   ones_next;

   // Decision from the stored integrator, then saturating integrator update
   always_comb begin
      bitstream = ~integ[INTEG_W-1];
      fb        = bitstream ? FB_POS : FB_NEG;
      sum       = {integ[INTEG_W-1], integ}
                + {{(SUM_W-DATA_W){analog_in[DATA_W-1]}}, analog_in}
                - fb;
      if (sum[SUM_W-1] != sum[SUM_W-2]) begin
         integ_next = sum[SUM_W-1] ? INTEG_MIN : INTEG_MAX;
      end else begin
         integ_next = sum[INTEG_W-1:0];
      end
      // A new frame counts from scratch regardless of any leftover count
      ones_next = (frame_start ? '0 : ones) + OSR_W'(bitstream);
   end

   // Integrator, running ones count and the completed-frame sample register
   always_ff @(posedge clk) begin
      if (reset) begin
         integ      <= '0;
         ones       <= '0;
         sample_out <= '0;
      end else if (en) begin
         integ <= integ_next;
         if (frame_end) begin
            sample_out <= ones_next;
            ones       <= '0;
         end else begin
            ones <= ones_next;
         end
      end
   end

endmodule

// File: rtl/sigma_delta_decimator.sv
// rtl/sigma_delta_decimator.sv - multi-channel sigma-delta modulator with boxcar decimator
module sigma_delta_decimator
   import sigma_delta_pkg::*;
#(
   parameter int DATA_W = 24,
   parameter int CH     = 2,
   parameter int OSR_W  = 8
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   input  logic [OSR_W-1:0]      osr_cfg,
   input  logic [CH*DATA_W-1:0]  analog_in,
   output logic [CH-1:0]         bitstream,
   output logic [CH*OSR_W-1:0]   sample_out,
   output logic                  sample_valid,
   input  logic                  sample_ready,
   output logic                  overrun,
   input  logic                  overrun_clr
);

   logic [OSR_W-1:0] fcnt;
   logic [OSR_W-1:0] osr_act;
   logic             frame_start;
   logic             frame_end;
   logic             accept;

   // Frame boundaries; osr_act is never below 2 so start and end never coincide
   always_comb begin
      frame_start = en && (fcnt == '0);
      frame_end   = en && (fcnt == osr_act - OSR_W'(1));
      accept      = sample_valid && sample_ready;
   end

   // Frame counter; the ratio is captured only at frame start
   always_ff @(posedge clk) begin
      if (reset) begin
         fcnt    <= '0;
         osr_act <= OSR_W'(OSR_MIN);
      end else if (en) begin
         if (frame_start) begin
            osr_act <= OSR_W'(clamp_osr(32'(osr_cfg)));
         end
         fcnt <= frame_end ? '0 : fcnt + OSR_W'(1);
      end
   end

   // Output handshake and sticky overrun; a new frame beats both accept and clear
   always_ff @(posedge clk) begin
      if (reset) begin
         sample_valid <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         if (frame_end) begin
            sample_valid <= 1'b1;
         end else if (accept) begin
            sample_valid <= 1'b0;
         end
         if (frame_end && sample_valid && !sample_ready) begin
            overrun <= 1'b1;
         end else if (overrun_clr) begin
            overrun <= 1'b0;
         end
      end
   end

   for (genvar c = 0; c < CH; c++) begin : g_ch
      sd_mod_ch #(
         .DATA_W (DATA_W),
         .OSR_W  (OSR_W)
      ) u_ch (
         .clk         (clk),
         .reset       (reset),
         .en          (en),
         .frame_start (frame_start),
         .frame_end   (frame_end),
         .analog_in   (analog_in[c*DATA_W +: DATA_W]),
         .bitstream   (bitstream[c]),
         .sample_out  (sample_out[c*OSR_W +: OSR_W])
      );
   end

endmodule

// File: tb/tb_sigma_delta_decimator.sv
// tb/tb_sigma_delta_decimator.sv - directed self-checking bench for sigma_delta_decimator
module tb_sigma_delta_decimator;

   localparam int DATA_W = 24;
   localparam int CH     = 2;
   localparam int OSR_W  = 8;

   localparam logic [DATA_W-1:0] IN_MIN = 24'h800000;
   localparam logic [DATA_W-1:0] IN_MAX = 24'h7fffff;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 en;
   logic [OSR_W-1:0]     osr_cfg;
   logic [CH*DATA_W-1:0] analog_in;
   logic [CH-1:0]        bitstream;
   logic [CH*OSR_W-1:0]  sample_out;
   logic                 sample_valid;
   logic                 sample_ready;
   logic                 overrun;
   logic                 overrun_clr;

   int errors = 0;
   int checks = 0;

   sigma_delta_decimator #(
      .DATA_W (DATA_W),
      .CH     (CH),
      .OSR_W  (OSR_W)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .en           (en),
      .osr_cfg      (osr_cfg),
      .analog_in    (analog_in),
      .bitstream    (bitstream),
      .sample_out   (sample_out),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .overrun      (overrun),
      .overrun_clr  (overrun_clr)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      reset = 1'b1;
      en    = 1'b0;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1; en = 1'b1; osr_cfg = 8'd16; analog_in = '0;
      sample_ready = 1'b1; overrun_clr = 1'b0;
      tick(); tick();
      checks++;
      if (bitstream !== 2'b11) begin errors++; $display("FAIL reset_bits got=%b exp=11", bitstream); end
      checks++;
      if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", sample_valid); end
      checks++;
      if (sample_out !== 16'h0000) begin errors++; $display("FAIL reset_sample got=%h exp=0000", sample_out); end
      checks++;
      if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
      reset = 1'b0;
   endtask

   task automatic test_zero_input;
      do_reset();
      osr_cfg = 8'd16; analog_in = '0; sample_ready = 1'b1; en = 1'b1;
      for (int k = 1; k <= 48; k++) begin
         tick();
         checks++;
         if (bitstream !== ((k % 2 == 0) ? 2'b11 : 2'b00)) begin
            errors++; $display("FAIL zero_bits k=%0d got=%b", k, bitstream);
         end
         checks++;
         if (sample_valid !== (k % 16 == 0)) begin
            errors++; $display("FAIL zero_valid k=%0d got=%b exp=%b", k, sample_valid, (k % 16 == 0));
         end
         if (k % 16 == 0) begin
            checks++;
            if (sample_out !== 16'h0808) begin
               errors++; $display("FAIL zero_sample k=%0d got=%h exp=0808", k, sample_out);
            end
         end
      end
   endtask

   task automatic test_extremes;
      logic [7:0] exp0;
      logic [7:0] exp1;
      do_reset();
      osr_cfg = 8'd16; analog_in = {IN_MAX, IN_MIN}; sample_ready = 1'b1; en = 1'b1;
      for (int k = 1; k <= 64; k++) begin
         tick();
         if (k % 16 == 0) begin
            exp0 = (k == 16) ? 8'd1 : 8'd0;
            exp1 = (k == 16) ? 8'd15 : 8'd16;
            checks++;
            if (sample_out[7:0] !== exp0) begin
               errors++; $display("FAIL ext_ch0 k=%0d got=%0d exp=%0d", k, sample_out[7:0], exp0);
            end
            checks++;
            if (sample_out[15:8] !== exp1) begin
               errors++; $display("FAIL ext_ch1 k=%0d got=%0d exp=%0d", k, sample_out[15:8], exp1);
            end
         end
      end
   endtask

   task automatic test_osr_change;
      logic exp_v;
      do_reset();
      osr_cfg = 8'd16; analog_in = '0; sample_ready = 1'b1; en = 1'b1;
      for (int k = 1; k <= 80; k++) begin
         tick();
         if (k == 5) osr_cfg = 8'd32;
         exp_v = (k == 16) || (k == 48) || (k == 80);
         checks++;
         if (sample_valid !== exp_v) begin
            errors++; $display("FAIL osrchg_valid k=%0d got=%b exp=%b", k, sample_valid, exp_v);
         end
         if (exp_v) begin
            checks++;
            if (sample_out !== ((k == 16) ? 16'h0808 : 16'h1010)) begin
               errors++; $display("FAIL osrchg_sample k=%0d got=%h", k, sample_out);
            end
         end
      end
   endtask

   task automatic test_overrun;
      do_reset();
      osr_cfg = 8'd4; analog_in = {IN_MAX, IN_MIN}; sample_ready = 1'b0;
      overrun_clr = 1'b0; en = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         tick();
         if (k >= 4 && k <= 7) begin
            checks++;
            if (sample_out !== 16'h0301 || sample_valid !== 1'b1 || overrun !== 1'b0) begin
               errors++; $display("FAIL ovr_hold k=%0d got=%h/%b/%b exp=0301/1/0", k, sample_out, sample_valid, overrun);
            end
         end
      end
      checks++;
      if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set got=%b exp=1", overrun); end
      checks++;
      if (sample_out !== 16'h0400 || sample_valid !== 1'b1) begin
         errors++; $display("FAIL ovr_second got=%h/%b exp=0400/1", sample_out, sample_valid);
      end
      en = 1'b0; overrun_clr = 1'b1;
      tick();
      checks++;
      if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clr got=%b exp=0", overrun); end
      checks++;
      if (bitstream !== 2'b10) begin errors++; $display("FAIL ovr_bits_hold got=%b exp=10", bitstream); end
      // clear held across the next frame end: the new overrun must still be recorded
      en = 1'b1;
      for (int k = 9; k <= 12; k++) begin
         tick();
         checks++;
         if (overrun !== (k == 12)) begin
            errors++; $display("FAIL ovr_setwins k=%0d got=%b exp=%b", k, overrun, (k == 12));
         end
      end
      en = 1'b0;
      tick();
      overrun_clr = 1'b0;
      checks++;
      if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clr2 got=%b exp=0", overrun); end
      en = 1'b1;
      tick(); tick(); tick();
      sample_ready = 1'b1;
      tick();
      checks++;
      if (sample_valid !== 1'b1 || overrun !== 1'b0 || sample_out !== 16'h0400) begin
         errors++; $display("FAIL ovr_accept_end got=%b/%b/%h exp=1/0/0400", sample_valid, overrun, sample_out);
      end
      en = 1'b0;
      tick();
      checks++;
      if (sample_valid !== 1'b0) begin errors++; $display("FAIL ovr_accept got=%b exp=0", sample_valid); end
   endtask

   task automatic test_osr_clamp;
      for (int cfg = 0; cfg <= 1; cfg++) begin
         do_reset();
         osr_cfg = 8'(cfg); analog_in = '0; sample_ready = 1'b1; en = 1'b1;
         for (int k = 1; k <= 8; k++) begin
            tick();
            checks++;
            if (sample_valid !== (k % 2 == 0)) begin
               errors++; $display("FAIL clamp_valid cfg=%0d k=%0d got=%b", cfg, k, sample_valid);
            end
            if (k % 2 == 0) begin
               checks++;
               if (sample_out !== 16'h0101) begin
                  errors++; $display("FAIL clamp_sample cfg=%0d k=%0d got=%h exp=0101", cfg, k, sample_out);
               end
            end
         end
      end
   endtask

   task automatic test_sparse_en_reset;
      int e;
      logic exp_v;
      do_reset();
      osr_cfg = 8'd4; analog_in = '0; sample_ready = 1'b1;
      e = 0;
      for (int c = 0; c < 30; c++) begin
         en = (c % 3 == 0);
         tick();
         if (en) e++;
         exp_v = en && (e % 4 == 0);
         checks++;
         if (bitstream !== ((e % 2 == 0) ? 2'b11 : 2'b00) || sample_valid !== exp_v) begin
            errors++; $display("FAIL sparse c=%0d got=%b/%b exp_v=%b", c, bitstream, sample_valid, exp_v);
         end
         if (exp_v) begin
            checks++;
            if (sample_out !== 16'h0202) begin errors++; $display("FAIL sparse_sample c=%0d got=%h exp=0202", c, sample_out); end
         end
      end
      osr_cfg = 8'd6; reset = 1'b1; en = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if (bitstream !== 2'b11 || sample_valid !== 1'b0 || sample_out !== 16'h0000 || overrun !== 1'b0) begin
         errors++; $display("FAIL midreset got=%b/%b/%h/%b exp=11/0/0000/0", bitstream, sample_valid, sample_out, overrun);
      end
      e = 0;
      for (int c = 0; c < 36; c++) begin
         en = (c % 3 == 0);
         tick();
         if (en) e++;
         exp_v = en && (e % 6 == 0);
         checks++;
         if (bitstream !== ((e % 2 == 0) ? 2'b11 : 2'b00) || sample_valid !== exp_v) begin
            errors++; $display("FAIL post_reset c=%0d got=%b/%b exp_v=%b", c, bitstream, sample_valid, exp_v);
         end
         if (exp_v) begin
            checks++;
            if (sample_out !== 16'h0303) begin errors++; $display("FAIL post_reset_sample c=%0d got=%h exp=0303", c, sample_out); end
         end
      end
   endtask

   initial begin
      reset = 1'b1; en = 1'b0; osr_cfg = '0; analog_in = '0;
      sample_ready = 1'b0; overrun_clr = 1'b0;
      test_reset();
      test_zero_input();
      test_extremes();
      test_osr_change();
      test_overrun();
      test_osr_clamp();
      test_sparse_en_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
